issueint_pipe: RTL

Parametrised, pipelined integer execute unit for the Tomasulo back end. Accepts one issued integer op per cycle from the integer issue queue over a valid/ready handshake and computes an ALU or branch-compare result. The result travels through PIPE_STAGES registered stages and is presented to the CDB arbiter over a second valid/ready handshake. Supports back-pressure, bubble collapsing and a pipeline flush on branch mispredict.

---
 rtl/issueint_pipe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/issueint_pipe.sv
// Pipelined integer execute unit: ALU/branch-compare result over PIPE_STAGES.
// Optional shifter ops C/D/E enabled by ISSUEINT_PIPE_SHIFT_EN.
module issueint_pipe #(
   parameter int DATA_W      = 32,
   parameter int TAG_W       = 6,
   parameter int PIPE_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [DATA_W-1:0] in_rsdata,
   input  logic [DATA_W-1:0] in_rtdata,
   input  logic [TAG_W-1:0]  in_rdtag,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_rdtag,
   output logic              out_overflow,
   output logic              out_carryout,
   output logic              out_branch,
   output logic              out_branch_taken
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
      logic              ovf;
      logic              cout;
      logic              br;
      logic              taken;
   } res_t;

   res_t              res;
   res_t              stg [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] vld;
   logic [PIPE_STAGES-1:0] adv;
   logic              empty_up;
   logic              load0;
   logic [DATA_W:0]   add_w;
   logic [DATA_W:0]   sub_w;
   logic              a_msb;
   logic              b_msb;
   logic              add_ovf;
   logic              sub_ovf;

   assign add_w = {1'b0, in_rsdata} + {1'b0, in_rtdata};
   assign sub_w = {1'b0, in_rsdata} + {1'b0, ~in_rtdata}
                + {{DATA_W{1'b0}}, 1'b1};
   assign a_msb = in_rsdata[DATA_W-1];
   assign b_msb = in_rtdata[DATA_W-1];
   assign add_ovf = (a_msb == b_msb) && (add_w[DATA_W-1] != a_msb);
   assign sub_ovf = (a_msb != b_msb) && (sub_w[DATA_W-1] != a_msb);

`ifdef ISSUEINT_PIPE_SHIFT_EN
   localparam int SH_W = $clog2(DATA_W);
   logic [SH_W-1:0] shamt;
   assign shamt = in_rsdata[SH_W-1:0];
`endif

   always_comb begin
      res     = '0;
      res.tag = in_rdtag;
      case (in_opcode)
         4'h0: begin
            res.data = add_w[DATA_W-1:0];
            res.cout = add_w[DATA_W];
            res.ovf  = add_ovf;
         end
         4'h1: begin
            res.data = add_w[DATA_W-1:0];
            res.cout = add_w[DATA_W];
         end
         4'h2: begin
            res.data = sub_w[DATA_W-1:0];
            res.cout = sub_w[DATA_W];
            res.ovf  = sub_ovf;
         end
         4'h3: begin
            res.data = sub_w[DATA_W-1:0];
            res.cout = sub_w[DATA_W];
         end
         4'h4: res.data = in_rsdata & in_rtdata;
         4'h5: res.data = in_rsdata | in_rtdata;
         4'h6: res.data = ~(in_rsdata | in_rtdata);
         4'h7: res.data = {{(DATA_W-1){1'b0}},
                           $signed(in_rsdata) < $signed(in_rtdata)};
         4'h8: res.data = {{(DATA_W-1){1'b0}}, in_rsdata < in_rtdata};
         4'h9: begin
            res.br    = 1'b1;
            res.taken = in_rsdata == in_rtdata;
         end
         4'hA: begin
            res.br    = 1'b1;
            res.taken = in_rsdata != in_rtdata;
         end
         4'hB: res.data = in_rsdata ^ in_rtdata;
`ifdef ISSUEINT_PIPE_SHIFT_EN
         4'hC: res.data = in_rtdata << shamt;
         4'hD: res.data = in_rtdata >> shamt;
         4'hE: res.data = $signed(in_rtdata) >>> shamt;
`else
         4'hC, 4'hD, 4'hE: res.data = '0;
`endif
         default: res.data = '0;
      endcase
   end

   // A stage may move on when out_ready is high or any stage below it is empty
   always_comb begin
      adv      = '0;
      empty_up = 1'b0;
      for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
         adv[k]   = out_ready || empty_up;
         empty_up = empty_up || !vld[k];
      end
   end

   assign load0    = !vld[0] || adv[0];
   assign in_ready = !flush && load0;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) stg[k] <= '0;
      end else if (flush) begin
         vld <= '0;
      end else begin
         if (load0) begin
            vld[0] <= in_valid;
            if (in_valid) stg[0] <= res;
         end
         for (int k = 1; k < PIPE_STAGES; k++) begin
            if (adv[k-1]) begin
               vld[k] <= vld[k-1];
               if (vld[k-1]) stg[k] <= stg[k-1];
            end
         end
      end
   end

   assign out_valid        = vld[PIPE_STAGES-1];
   assign out_data         = stg[PIPE_STAGES-1].data;
   assign out_rdtag        = stg[PIPE_STAGES-1].tag;
   assign out_overflow     = stg[PIPE_STAGES-1].ovf;
   assign out_carryout     = stg[PIPE_STAGES-1].cout;
   assign out_branch       = stg[PIPE_STAGES-1].br;
   assign out_branch_taken = stg[PIPE_STAGES-1].taken;

endmodule
